// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder: takes a CMD_WIDTH-bit command on MOSI, then returns a RESP_WIDTH-bit sample on MISO.
// Define SPI_RESP_CMD_CHECK_EN so that only READ_CMD is answered; by default every command returns sample_i.
`timescale 1ns/1ps
module spi_adc_responder #(
  parameter int                   CMD_WIDTH   = 8,
  parameter int                   RESP_WIDTH  = 24,
  parameter logic [CMD_WIDTH-1:0] READ_CMD    = 8'h87,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  SCLK_i,
  input  logic                  CS_i,
  input  logic                  MOSI_i,
  output logic                  MISO_o,
  input  logic [RESP_WIDTH-1:0] sample_i,
  output logic [CMD_WIDTH-1:0]  cmd_o,
  output logic                  cmd_valid_o,
  output logic                  done_o,
  output logic                  frame_error_o,
  output logic                  busy_o
);

  localparam int MAX_W = (CMD_WIDTH > RESP_WIDTH) ? CMD_WIDTH : RESP_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // The extra top flop on SCLK/CS is the "previous" sample used for edge detection.
  logic [SYNC_STAGES:0]   r_sclk_sync;
  logic [SYNC_STAGES:0]   r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_mosi;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CMD_WIDTH-2:0]  r_cmd_sr;
  logic [RESP_WIDTH-2:0] r_resp_sr;
  logic                  r_miso;
  logic [CMD_WIDTH-1:0]  r_cmd;
  logic                  r_cmd_valid;
  logic                  r_done;
  logic                  r_frame_error;
  logic                  r_complete;
  logic                  r_busy;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CMD_WIDTH-2:0]  w_cmd_sr_nxt;
  logic [RESP_WIDTH-2:0] w_resp_sr_nxt;
  logic                  w_miso_nxt;
  logic [CMD_WIDTH-1:0]  w_cmd_nxt;
  logic                  w_cmd_valid_nxt;
  logic                  w_done_nxt;
  logic                  w_frame_error_nxt;
  logic                  w_complete_nxt;
  logic [CMD_WIDTH-1:0]  w_cmd_shift;
  logic                  w_is_read;
  logic                  w_accept;

  // Input synchronizers for the asynchronous SPI pins.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-1:0], SCLK_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-1:0], CS_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI_i};
    end
  end

  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_sync[SYNC_STAGES];
  assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_sync[SYNC_STAGES];
  assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_sync[SYNC_STAGES];
  assign w_cs_rise   = r_cs_sync[SYNC_STAGES-1] & ~r_cs_sync[SYNC_STAGES];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];

  assign w_cmd_shift = {r_cmd_sr, w_mosi};
  assign w_is_read   = (w_cmd_shift == READ_CMD);
`ifdef SPI_RESP_CMD_CHECK_EN
  assign w_accept    = w_is_read;
`else
  // Every command is answered; the READ_CMD match only matters with the check enabled.
  assign w_accept    = w_is_read | 1'b1;
`endif

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_cmd_sr_nxt      = r_cmd_sr;
    w_resp_sr_nxt     = r_resp_sr;
    w_miso_nxt        = r_miso;
    w_cmd_nxt         = r_cmd;
    w_cmd_valid_nxt   = 1'b0;
    w_done_nxt        = 1'b0;
    w_frame_error_nxt = 1'b0;
    w_complete_nxt    = r_complete;
    case (r_state)
      ST_IDLE: begin
        w_miso_nxt = 1'b0;
        if (w_cs_fall) begin
          w_state_nxt    = ST_CMD;
          w_cnt_nxt      = '0;
          w_cmd_sr_nxt   = '0;
          w_complete_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (w_cs_rise) begin
          w_state_nxt       = ST_IDLE;
          w_frame_error_nxt = 1'b1;
          w_miso_nxt        = 1'b0;
          w_cnt_nxt         = '0;
        end else if (w_sclk_rise) begin
          w_cmd_sr_nxt = w_cmd_shift[CMD_WIDTH-2:0];
          if (r_cnt == CNT_W'(CMD_WIDTH - 1)) begin
            w_cmd_nxt       = w_cmd_shift;
            w_cmd_valid_nxt = 1'b1;
            w_cnt_nxt       = '0;
            if (w_accept) begin
              w_resp_sr_nxt = sample_i[RESP_WIDTH-2:0];
              w_miso_nxt    = sample_i[RESP_WIDTH-1];
              w_state_nxt   = ST_RESP;
            end else begin
              w_miso_nxt     = 1'b0;
              w_complete_nxt = 1'b0;
              w_state_nxt    = ST_DRAIN;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_state_nxt = ST_CMD;
        end
      end
      ST_RESP: begin
        // The fall right after the last command bit keeps the MSB, which was loaded on that rise.
        if (w_cs_rise) begin
          w_state_nxt       = ST_IDLE;
          w_frame_error_nxt = 1'b1;
          w_miso_nxt        = 1'b0;
          w_cnt_nxt         = '0;
          w_resp_sr_nxt     = '0;
        end else if (w_sclk_rise) begin
          if (r_cnt == CNT_W'(RESP_WIDTH - 1)) begin
            w_miso_nxt     = 1'b0;
            w_cnt_nxt      = '0;
            w_complete_nxt = 1'b1;
            w_state_nxt    = ST_DRAIN;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else if (w_sclk_fall) begin
          if (r_cnt != '0) begin
            w_miso_nxt    = r_resp_sr[RESP_WIDTH-2];
            w_resp_sr_nxt = {r_resp_sr[RESP_WIDTH-3:0], 1'b0};
          end else begin
            w_miso_nxt = r_miso;
          end
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_DRAIN: begin
        w_miso_nxt = 1'b0;
        if (w_cs_rise) begin
          w_state_nxt       = ST_IDLE;
          w_done_nxt        = r_complete;
          w_frame_error_nxt = ~r_complete;
          w_complete_nxt    = 1'b0;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_miso_nxt  = 1'b0;
      end
    endcase
  end

  // Frame state and registered outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_cmd_sr      <= '0;
      r_resp_sr     <= '0;
      r_miso        <= 1'b0;
      r_cmd         <= '0;
      r_cmd_valid   <= 1'b0;
      r_done        <= 1'b0;
      r_frame_error <= 1'b0;
      r_complete    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cmd_sr      <= w_cmd_sr_nxt;
      r_resp_sr     <= w_resp_sr_nxt;
      r_miso        <= w_miso_nxt;
      r_cmd         <= w_cmd_nxt;
      r_cmd_valid   <= w_cmd_valid_nxt;
      r_done        <= w_done_nxt;
      r_frame_error <= w_frame_error_nxt;
      r_complete    <= w_complete_nxt;
      r_busy        <= (w_state_nxt == ST_CMD) || (w_state_nxt == ST_RESP);
    end
  end

  assign MISO_o        = r_miso;
  assign cmd_o         = r_cmd;
  assign cmd_valid_o   = r_cmd_valid;
  assign done_o        = r_done;
  assign frame_error_o = r_frame_error;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Self-checking bench for spi_adc_responder: a table of SPI frames plus a reset-mid-response sequence.
`timescale 1ns/1ps
module tb_spi_adc_responder;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        SCLK_i;
  logic        CS_i;
  logic        MOSI_i;
  logic        MISO_o;
  logic [23:0] sample_i;
  logic [7:0]  cmd_o;
  logic        cmd_valid_o;
  logic        done_o;
  logic        frame_error_o;
  logic        busy_o;

  spi_adc_responder dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .SCLK_i       (SCLK_i),
    .CS_i         (CS_i),
    .MOSI_i       (MOSI_i),
    .MISO_o       (MISO_o),
    .sample_i     (sample_i),
    .cmd_o        (cmd_o),
    .cmd_valid_o  (cmd_valid_o),
    .done_o       (done_o),
    .frame_error_o(frame_error_o),
    .busy_o       (busy_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] sample;
    int          cmd_bits;
    int          resp_bits;
    logic [31:0] exp_rx;
    int          exp_cv;
    int          exp_done;
    int          exp_ferr;
    logic [7:0]  exp_cmd;
  } vec_t;

  vec_t vecs [9];

  int n_cmp = 0;
  int n_err = 0;
  int cv_cycles = 0;
  int done_cycles = 0;
  int ferr_cycles = 0;
  logic [7:0] exp_cmd_q [$];
  logic [7:0] got_cmd_q [$];

  // Pulse monitor: counts high cycles of each strobe and records cmd_o at each cmd_valid_o.
  always @(negedge clock_i) begin
    if (cmd_valid_o) begin
      cv_cycles++;
      got_cmd_q.push_back(cmd_o);
    end
    if (done_o) done_cycles++;
    if (frame_error_o) ferr_cycles++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic half_sclk();
    repeat (5) @(negedge clock_i);
  endtask

  // One master frame at clock_i/10; optionally leaves CS low at the end.
  task automatic spi_frame(input logic [7:0] cmd, input logic [23:0] sample, input int cmd_bits,
                           input int resp_bits, input bit raise_cs, output logic [31:0] rx);
    rx = 32'h0;
    sample_i = sample;
    repeat (2) begin
      half_sclk(); SCLK_i = 1'b1; half_sclk(); SCLK_i = 1'b0;
    end
    half_sclk();
    CS_i = 1'b0;
    half_sclk();
    for (int i = 0; i < cmd_bits; i++) begin
      MOSI_i = cmd[7-i];
      half_sclk(); SCLK_i = 1'b1; half_sclk(); SCLK_i = 1'b0;
    end
    MOSI_i = 1'b0;
    for (int i = 0; i < resp_bits; i++) begin
      half_sclk();
      rx = {rx[30:0], MISO_o};
      SCLK_i = 1'b1; half_sclk(); SCLK_i = 1'b0;
    end
    if (raise_cs) begin
      half_sclk();
      CS_i = 1'b1;
      repeat (20) @(negedge clock_i);
    end
  endtask

  task automatic sb_drain(input string tag);
    logic [7:0] g;
    while (got_cmd_q.size() > 0) begin
      g = got_cmd_q.pop_front();
      if (exp_cmd_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s sb_unexpected_cmd: got %h, want none", tag, g);
      end else begin
        check({tag, " sb_cmd"}, {24'h0, g}, {24'h0, exp_cmd_q.pop_front()});
      end
    end
    check({tag, " sb_pending"}, exp_cmd_q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] rx;
    int cv0, d0, f0;

    vecs[0] = '{8'h87, 24'hAABBCC, 8, 24, 32'h00AABBCC, 1, 1, 0, 8'h87};
    vecs[1] = '{8'h87, 24'h123456, 8, 24, 32'h00123456, 1, 1, 0, 8'h87};
    vecs[2] = '{8'h87, 24'hFEDCBA, 8, 24, 32'h00FEDCBA, 1, 1, 0, 8'h87};
`ifdef SPI_RESP_CMD_CHECK_EN
    vecs[3] = '{8'h55, 24'h3C3C3C, 8, 24, 32'h00000000, 1, 0, 1, 8'h55};
`else
    vecs[3] = '{8'h55, 24'h3C3C3C, 8, 24, 32'h003C3C3C, 1, 1, 0, 8'h55};
`endif
    vecs[4] = '{8'hA5, 24'h111111, 5, 0, 32'h00000000, 0, 0, 1, 8'h55};
    vecs[5] = '{8'h87, 24'h5A5A5A, 8, 10, 32'h00000169, 1, 0, 1, 8'h87};
    vecs[6] = '{8'h87, 24'h0F1E2D, 8, 24, 32'h000F1E2D, 1, 1, 0, 8'h87};
    vecs[7] = '{8'h87, 24'hC0FFEE, 8, 28, 32'h0C0FFEE0, 1, 1, 0, 8'h87};
`ifdef SPI_RESP_CMD_CHECK_EN
    vecs[8] = '{8'h00, 24'h800001, 8, 24, 32'h00000000, 1, 0, 1, 8'h00};
`else
    vecs[8] = '{8'h00, 24'h800001, 8, 24, 32'h00800001, 1, 1, 0, 8'h00};
`endif

    reset_i = 1'b1; SCLK_i = 1'b0; CS_i = 1'b1; MOSI_i = 1'b0; sample_i = 24'h0;
    repeat (3) @(negedge clock_i);
    check("rst_miso", {31'h0, MISO_o}, 32'd0);
    check("rst_cmd", {24'h0, cmd_o}, 32'd0);
    check("rst_busy", {31'h0, busy_o}, 32'd0);
    check("rst_pulses", {29'h0, cmd_valid_o, done_o, frame_error_o}, 32'd0);
    reset_i = 1'b0;
    repeat (6) @(negedge clock_i);
    check("idle_busy", {31'h0, busy_o}, 32'd0);
    check("idle_pulses", cv_cycles + done_cycles + ferr_cycles, 32'd0);

    // Reset asserted with CS still low after 12 response bits.
    cv0 = cv_cycles; d0 = done_cycles; f0 = ferr_cycles;
    exp_cmd_q.push_back(8'h87);
    spi_frame(8'h87, 24'h654A21, 8, 12, 1'b0, rx);
    check("rstmid_rx", rx, 32'h00000654);
    half_sclk();
    check("rstmid_busy_before", {31'h0, busy_o}, 32'd1);
    check("rstmid_miso_before", {31'h0, MISO_o}, 32'd1);
    reset_i = 1'b1;
    #1;
    check("rstmid_miso", {31'h0, MISO_o}, 32'd0);
    check("rstmid_busy", {31'h0, busy_o}, 32'd0);
    check("rstmid_cmd", {24'h0, cmd_o}, 32'd0);
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    repeat (3) @(negedge clock_i);
    CS_i = 1'b1;
    repeat (20) @(negedge clock_i);
    check("rstmid_cv", cv_cycles - cv0, 32'd1);
    check("rstmid_done", done_cycles - d0, 32'd0);
    check("rstmid_ferr", ferr_cycles - f0, 32'd0);
    sb_drain("rstmid");

    for (int v = 0; v < 9; v++) begin
      cv0 = cv_cycles; d0 = done_cycles; f0 = ferr_cycles;
      if (vecs[v].cmd_bits == 8) exp_cmd_q.push_back(vecs[v].cmd);
      spi_frame(vecs[v].cmd, vecs[v].sample, vecs[v].cmd_bits, vecs[v].resp_bits, 1'b1, rx);
      if (vecs[v].resp_bits > 0) check($sformatf("v%0d_rx", v), rx, vecs[v].exp_rx);
      check($sformatf("v%0d_cmd_valid", v), cv_cycles - cv0, vecs[v].exp_cv);
      check($sformatf("v%0d_done", v), done_cycles - d0, vecs[v].exp_done);
      check($sformatf("v%0d_frame_error", v), ferr_cycles - f0, vecs[v].exp_ferr);
      check($sformatf("v%0d_cmd_o", v), {24'h0, cmd_o}, {24'h0, vecs[v].exp_cmd});
      check($sformatf("v%0d_miso_idle", v), {31'h0, MISO_o}, 32'd0);
      check($sformatf("v%0d_busy_idle", v), {31'h0, busy_o}, 32'd0);
      sb_drain($sformatf("v%0d", v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
